// File: rtl/clk_div_pkg.sv
// Shared definitions for the clock-divider slice: default counter width and run/halt state.
package clk_div_pkg;

  localparam int unsigned DIV_W = 16;

  typedef enum logic [0:0] {
    ST_HALT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/tick_counter.sv
// Period counter: counts 0..terminal-1 and wraps, with a synchronous clear that overrides counting.
module tick_counter
  import clk_div_pkg::*;
#(
  parameter int unsigned W = DIV_W
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic [W-1:0] terminal_i,
  output logic [W-1:0] count_o,
  output logic         wrap_o
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    // Only meaningful while terminal_i is non-zero; the parent holds clr_i otherwise.
    wrap_o  = (count_q == terminal_i - W'(1));
    count_d = count_q + W'(1);
    if (clr_i || wrap_o) begin
      count_d = '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/tick_divider.sv
// Divide-by-D tick generator with a Load/Ack shadow-divisor handshake applied at period boundaries.
// Define TICK_DIVIDER_CLKOUT_EN to build the 50%-duty ClkOut flop; otherwise ClkOut is tied low.
module tick_divider
  import clk_div_pkg::*;
#(
  parameter int unsigned N           = DIV_W,
  parameter int unsigned DEFAULT_DIV = 2
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         Enable,
  input  logic [N-1:0] Divisor,
  input  logic         Load,
  output logic         Ack,
  output logic         Tick,
  output logic         ClkOut
);

  logic [N-1:0] active_q, active_d;
  logic [N-1:0] shadow_q, shadow_d;
  logic         pending_q, pending_d;
  logic         ack_q, ack_d;
  logic         tick_q, tick_d;
  logic [N-1:0] count;
  logic         wrap;
  logic         run;
  logic         apply;
  state_e       state;

  // State is decoded from the current Enable/Active so the first edge after Enable already counts.
  always_comb begin
    state = (Enable && (active_q != '0)) ? ST_RUN : ST_HALT;
    run   = (state == ST_RUN);
  end

  tick_counter #(
    .W (N)
  ) u_tick_counter (
    .clk_i      (Clk),
    .rst_i      (Reset),
    .clr_i      (!run),
    .terminal_i (active_q),
    .count_o    (count),
    .wrap_o     (wrap)
  );

  always_comb begin
    active_d  = active_q;
    shadow_d  = shadow_q;
    pending_d = pending_q;
    apply     = pending_q && (!run || wrap);
    if (apply) begin
      active_d  = shadow_q;
      pending_d = 1'b0;
    end
    // A Load on the apply edge queues behind the value being applied.
    if (Load) begin
      shadow_d  = Divisor;
      pending_d = 1'b1;
    end
    ack_d  = apply;
    tick_d = run && wrap;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      active_q  <= N'(DEFAULT_DIV);
      shadow_q  <= '0;
      pending_q <= 1'b0;
      ack_q     <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      active_q  <= active_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      ack_q     <= ack_d;
      tick_q    <= tick_d;
    end
  end

  assign Ack  = ack_q;
  assign Tick = tick_q;

`ifdef TICK_DIVIDER_CLKOUT_EN
  logic clk_out_q, clk_out_d;

  always_comb begin
    clk_out_d = clk_out_q;
    if (!run) begin
      clk_out_d = 1'b0;
    end else if (wrap) begin
      clk_out_d = ~clk_out_q;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      clk_out_q <= 1'b0;
    end else begin
      clk_out_q <= clk_out_d;
    end
  end

  assign ClkOut = clk_out_q;
`else
  assign ClkOut = 1'b0;
`endif

  logic unused_count;
  assign unused_count = ^count;

endmodule

// File: tb/tb_tick_divider.sv
// Directed self-checking bench for tick_divider (DEFAULT_DIV=2); ClkOut expectations follow the build macro.
module tb_tick_divider;

  localparam int unsigned N = 16;
`ifdef TICK_DIVIDER_CLKOUT_EN
  localparam bit CoEn = 1'b1;
`else
  localparam bit CoEn = 1'b0;
`endif

  logic         Clk;
  logic         Reset;
  logic         Enable;
  logic [N-1:0] Divisor;
  logic         Load;
  logic         Ack;
  logic         Tick;
  logic         ClkOut;

  int n_total;
  int n_pass;

  tick_divider #(
    .N           (N),
    .DEFAULT_DIV (2)
  ) dut (
    .Clk     (Clk),
    .Reset   (Reset),
    .Enable  (Enable),
    .Divisor (Divisor),
    .Load    (Load),
    .Ack     (Ack),
    .Tick    (Tick),
    .ClkOut  (ClkOut)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total = n_total + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chk3(input string tag, input logic t, input logic c, input logic a);
    chk({tag, "_tick"}, 32'(Tick), 32'(t));
    chk({tag, "_clkout"}, 32'(ClkOut), 32'(c & CoEn));
    chk({tag, "_ack"}, 32'(Ack), 32'(a));
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    Reset   = 1'b1;
    Enable  = 1'b0;
    Load    = 1'b0;
    Divisor = '0;
    repeat (2) @(posedge Clk);
    #1;
    chk3("reset", 0, 0, 0);

    // Default divisor 2
    Reset = 1'b0;
    Enable = 1'b1;
    step(); chk3("d2_e1", 0, 0, 0);
    step(); chk3("d2_e2", 1, 1, 0);
    step(); chk3("d2_e3", 0, 1, 0);
    step(); chk3("d2_e4", 1, 0, 0);
    step(); chk3("d2_e5", 0, 0, 0);
    step(); chk3("d2_e6", 1, 1, 0);

    // Switch to 5, then load 3 at Count=1
    Load = 1'b1; Divisor = 16'd5;
    step(); Load = 1'b0; chk3("ld5_cap", 0, 1, 0);
    step(); chk3("ld5_apply", 1, 0, 1);
    step(); chk3("d5_c1", 0, 0, 0);
    Load = 1'b1; Divisor = 16'd3;
    step(); Load = 1'b0; chk3("ld3_c2", 0, 0, 0);
    step(); chk3("ld3_c3", 0, 0, 0);
    step(); chk3("ld3_c4", 0, 0, 0);
    step(); chk3("ld3_apply", 1, 1, 1);
    step(); chk3("d3_c1", 0, 1, 0);
    step(); chk3("d3_c2", 0, 1, 0);
    step(); chk3("d3_tick1", 1, 0, 0);
    step(); step(); step(); chk3("d3_tick2", 1, 1, 0);

    // Back-to-back loads 7 then 9: one Ack, period 9
    Load = 1'b1; Divisor = 16'd7;
    step(); chk3("ld7", 0, 1, 0);
    Divisor = 16'd9;
    step(); Load = 1'b0; chk3("ld9", 0, 1, 0);
    step(); chk3("ld9_apply", 1, 0, 1);
    for (int i = 0; i < 8; i++) begin
      step(); chk3("d9_gap", 0, 0, 0);
    end
    step(); chk3("d9_tick", 1, 1, 0);

    // Move to 4, then load 0 to halt
    Load = 1'b1; Divisor = 16'd4;
    step(); Load = 1'b0; chk3("ld4_cap", 0, 1, 0);
    repeat (7) step();
    chk3("ld4_wait", 0, 1, 0);
    step(); chk3("ld4_apply", 1, 0, 1);
    Load = 1'b1; Divisor = 16'd0;
    step(); Load = 1'b0; chk3("ld0_c1", 0, 0, 0);
    step(); step(); chk3("ld0_c3", 0, 0, 0);
    step(); chk3("ld0_apply", 1, 1, 1);
    for (int i = 0; i < 6; i++) begin
      step(); chk3("halt", 0, 0, 0);
    end
    Load = 1'b1; Divisor = 16'd2;
    step(); Load = 1'b0; chk3("ld2_cap", 0, 0, 0);
    step(); chk3("ld2_apply", 0, 0, 1);
    step(); chk3("resume_c1", 0, 0, 0);
    step(); chk3("resume_tick", 1, 1, 0);

    // Divisor 6, drop Enable at Count=2
    Load = 1'b1; Divisor = 16'd6;
    step(); Load = 1'b0; chk3("ld6_cap", 0, 1, 0);
    step(); chk3("ld6_apply", 1, 0, 1);
    repeat (5) step();
    chk3("d6_c5", 0, 0, 0);
    step(); chk3("d6_tick", 1, 1, 0);
    step(); step();
    Enable = 1'b0;
    step(); chk3("en_drop", 0, 0, 0);
    step(); chk3("en_low", 0, 0, 0);
    Enable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(); chk3("reen_gap", 0, 0, 0);
    end
    step(); chk3("reen_tick", 1, 1, 0);

    // Reset while a load is pending
    Load = 1'b1; Divisor = 16'd5;
    step(); Load = 1'b0; chk3("rst_ld", 0, 1, 0);
    Reset = 1'b1;
    #1; chk3("rst_async", 0, 0, 0);
    step(); chk3("rst_held", 0, 0, 0);
    Reset = 1'b0;
    step(); chk3("rst_c1", 0, 0, 0);
    step(); chk3("rst_tick1", 1, 1, 0);
    step(); chk3("rst_c1b", 0, 1, 0);
    step(); chk3("rst_tick2", 1, 0, 0);

    // Divisor 1: continuous Tick, ClkOut toggles every cycle
    Load = 1'b1; Divisor = 16'd1;
    step(); Load = 1'b0; chk3("ld1_cap", 0, 0, 0);
    step(); chk3("ld1_apply", 1, 1, 1);
    step(); chk3("d1_a", 1, 0, 0);
    step(); chk3("d1_b", 1, 1, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
